// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg: shared FSM encoding, slave decode and default timeout for the APB master arbiter
package apb_ctrl_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_DONE   = 2'd3;
  localparam int TIMEOUT_DEF = 16;
  localparam int SLV_BIT = 5;
  localparam logic SLV_GPIO = 1'b0;
  localparam logic SLV_UART = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; pointer remembers the last granted requester
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_idx
);
  logic last_q, last_d;
  always_comb begin
    gnt_valid = en && |req;
    gnt_idx = &req ? ~last_q : req[1];
    last_d = gnt_valid ? gnt_idx : last_q;
  end
  // reset value 1 makes requester 0 win the first contention
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_q <= 1'b1;
    else last_q <= last_d;
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: arbitrates two requesters onto one APB master driving GPIO and UART slaves
module apb_master_arbiter
  import apb_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [11:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        psel_gpio,
  output logic        psel_uart,
  output logic        penable,
  output logic        pwrite,
  output logic [4:0]  paddr,
  output logic [31:0] pwdata,
  input  logic        pready_gpio,
  input  logic        pready_uart,
  input  logic [31:0] prdata_gpio,
  input  logic [31:0] prdata_uart
);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  state_t state_q, state_d;
  logic gnt_q, gnt_d, wr_q, wr_d, err_q, err_d;
  logic psel_g_q, psel_g_d, psel_u_q, psel_u_d, penable_q, penable_d;
  logic [5:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] done_q, done_d;
  logic gnt_valid, gnt_idx, sel_ready, active;
  logic [31:0] sel_rdata;
  rr_arbiter2 u_arb (
    .clk(clk), .rst_n(rst_n), .req(req_valid), .en(state_q == ST_IDLE),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx)
  );
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    wr_d = wr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    cnt_d = cnt_q;
    rdata_d = rdata_q;
    err_d = err_q;
    sel_ready = addr_q[SLV_BIT] == SLV_UART ? pready_uart : pready_gpio;
    sel_rdata = addr_q[SLV_BIT] == SLV_UART ? prdata_uart : prdata_gpio;
    case (state_q)
      ST_IDLE: if (gnt_valid) begin
        state_d = ST_SETUP;
        gnt_d = gnt_idx;
        wr_d = req_write[gnt_idx];
        addr_d = gnt_idx ? req_addr[11:6] : req_addr[5:0];
        wdata_d = gnt_idx ? req_wdata[63:32] : req_wdata[31:0];
        cnt_d = '0;
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: if (sel_ready) begin
        state_d = ST_DONE;
        rdata_d = wr_q ? rdata_q : sel_rdata;
        err_d = 1'b0;
      end else if (cnt_q == TO_LAST) begin
        state_d = ST_DONE;
        rdata_d = '0;
        err_d = 1'b1;
      end else cnt_d = cnt_q + 8'd1;
      default: state_d = ST_IDLE;
    endcase
    // outputs are registered from the next state so they line up with the phase
    active = state_d == ST_SETUP || state_d == ST_ACCESS;
    psel_g_d = active && addr_d[SLV_BIT] == SLV_GPIO;
    psel_u_d = active && addr_d[SLV_BIT] == SLV_UART;
    penable_d = state_d == ST_ACCESS;
    done_d = state_d == ST_DONE ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      psel_g_q <= 1'b0;
      psel_u_q <= 1'b0;
      penable_q <= 1'b0;
      done_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      cnt_q <= cnt_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      psel_g_q <= psel_g_d;
      psel_u_q <= psel_u_d;
      penable_q <= penable_d;
      done_q <= done_d;
    end
  assign done = done_q;
  assign rdata = rdata_q;
  assign err = err_q;
  assign psel_gpio = psel_g_q;
  assign psel_uart = psel_u_q;
  assign penable = penable_q;
  assign pwrite = wr_q;
  assign paddr = addr_q[4:0];
  assign pwdata = wdata_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: scoreboard bench with requester/slave models and a transaction-level reference
module tb_apb_master_arbiter;
  localparam int TO = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_write = '0, done;
  logic [11:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [31:0] rdata, pwdata, prdata_gpio = '0, prdata_uart = '0;
  logic err, psel_gpio, psel_uart, penable, pwrite, pready_gpio = 1'b0, pready_uart = 1'b0;
  logic [4:0] paddr;
  typedef struct {
    int idx; logic wr; logic [5:0] addr; logic [31:0] wdata, sdata;
    int waits; logic [31:0] rdata; logic err; int cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0, failures = 0, acc = 0;
  logic mlast = 1'b1;
  logic [31:0] mrd = '0;
  logic p, s;

  apb_master_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done), .rdata(rdata), .err(err),
    .psel_gpio(psel_gpio), .psel_uart(psel_uart), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready_gpio(pready_gpio), .pready_uart(pready_uart),
    .prdata_gpio(prdata_gpio), .prdata_uart(prdata_uart)
  );
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // transfer outcome from the rules: success if pready arrives within TO access cycles
  task automatic push(input int i, input logic wr, input logic [5:0] a,
                      input logic [31:0] wd, input logic [31:0] sd, input int w);
    exp_t x;
    x.idx = i; x.wr = wr; x.addr = a; x.wdata = wd; x.sdata = sd; x.waits = w;
    if (w + 1 <= TO) begin x.err = 1'b0; x.rdata = wr ? mrd : sd; x.cyc = w + 1; end
    else begin x.err = 1'b1; x.rdata = '0; x.cyc = TO; end
    mrd = x.rdata;
    exp_q.push_back(x);
  endtask

  task automatic issue(input logic [1:0] m, input logic [1:0] wr, input logic [11:0] ad,
                       input logic [63:0] wd, input logic [63:0] sd, input int w0, input int w1);
    int f;
    @(negedge clk); #1;
    req_write = wr; req_addr = ad; req_wdata = wd;
    f = m == 2'b11 ? int'(!mlast) : (m[1] ? 1 : 0);
    for (int k = 0; k < (m == 2'b11 ? 2 : 1); k++) begin
      int i;
      i = k == 0 ? f : 1 - f;
      push(i, wr[i], ad[6*i +: 6], wd[32*i +: 32], sd[32*i +: 32], i == 1 ? w1 : w0);
    end
    if (m != 2'b11) mlast = f[0];
    req_valid = m;
    for (int c = 0; c < 200 && req_valid != 0; c++) begin @(negedge clk); #1; end
    chk("req_budget", req_valid, 0);
    if (req_valid != 0) begin req_valid = '0; exp_q.delete(); end
  endtask

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 9);
    return r < 7 ? $urandom_range(0, 3) : (r == 7 ? 15 : (r == 8 ? 14 : 255));
  endfunction

  // slave model, requester completion and scoreboard compare
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin acc = 0; pready_gpio = 1'b0; pready_uart = 1'b0; continue; end
      chk("psel_overlap", {1'b0, psel_gpio & psel_uart}, 0);
      if ((psel_gpio || psel_uart) && !penable) begin
        acc = 0;
        if (exp_q.size() == 0) chk("unexpected_setup", 1, 0);
        else begin
          e = exp_q[0];
          chk("psel_gpio", psel_gpio, !e.addr[5]);
          chk("psel_uart", psel_uart, e.addr[5]);
          chk("paddr", paddr, e.addr[4:0]);
          chk("pwrite", pwrite, e.wr);
          chk("pwdata", pwdata, e.wdata);
          req_write[e.idx] = 1'($urandom_range(0, 1));
          req_addr[6*e.idx +: 6] = 6'($urandom);
          req_wdata[32*e.idx +: 32] = $urandom;
        end
      end
      if (penable) acc++;
      if (done != 0) begin
        if (exp_q.size() == 0) chk("unexpected_done", done, 0);
        else begin
          e = exp_q.pop_front();
          chk("done", done, e.idx == 1 ? 2'b10 : 2'b01);
          chk("rdata", rdata, e.rdata);
          chk("err", err, e.err);
          chk("access_cycles", acc, e.cyc);
          req_valid[e.idx] = 1'b0;
        end
      end
      p = penable && exp_q.size() > 0 && acc > exp_q[0].waits;
      s = exp_q.size() > 0 ? exp_q[0].addr[5] : 1'b0;
      pready_gpio = s ? 1'($urandom_range(0, 1)) : p;
      pready_uart = s ? p : 1'($urandom_range(0, 1));
      prdata_gpio = (s || exp_q.size() == 0) ? $urandom : exp_q[0].sdata;
      prdata_uart = (!s || exp_q.size() == 0) ? $urandom : exp_q[0].sdata;
    end
  end

  initial begin
    #1;
    chk("rst_outputs", {done, err, psel_gpio, psel_uart, penable, pwrite, paddr}, 0);
    chk("rst_data", {rdata, pwdata}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    issue(2'b01, 2'b01, {6'h00, 6'h03}, {32'h0, 32'hA5A5_0001}, 64'h0, 0, 0);
    issue(2'b10, 2'b00, {6'h21, 6'h00}, 64'h0, {32'h1234_5678, 32'h0}, 0, 2);
    issue(2'b11, 2'b10, {6'h22, 6'h04}, {32'hCAFE_0002, 32'hBEEF_0001}, {32'h55, 32'h66}, 1, 0);
    issue(2'b11, 2'b01, {6'h07, 6'h26}, {32'h2, 32'h1}, {32'h77, 32'h88}, 0, 3);
    issue(2'b01, 2'b00, {6'h00, 6'h05}, 64'h0, 64'hDEAD, 255, 0);
    issue(2'b10, 2'b00, {6'h2A, 6'h00}, 64'h0, {32'h0BAD_F00D, 32'h0}, 0, 15);
    // reset in the middle of an access after requester 0 was granted last
    @(negedge clk); #1;
    req_write = 2'b00; req_addr = 12'h005;
    push(0, 1'b0, 6'h05, 32'h0, 32'h0, 255);
    req_valid = 2'b01;
    for (int c = 0; c < 20 && !penable; c++) begin @(negedge clk); #1; end
    chk("reach_access", penable, 1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_psel", {psel_gpio, psel_uart, penable}, 0);
    chk("rst_mid_done", {done, err}, 0);
    exp_q.delete(); req_valid = '0; mlast = 1'b1; mrd = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    issue(2'b11, 2'b11, {6'h31, 6'h11}, {32'h1111, 32'h0000}, 64'h0, 0, 0);
    for (int n = 0; n < 40; n++)
      issue(2'($urandom_range(1, 3)), 2'($urandom), 12'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, rand_wait(), rand_wait());
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
